// File: rtl/uart_ps2_line_parser.sv
// ---------------------------------------------------------------------------
// uart_ps2_line_parser
// Receive-side decoder for the PS2 status text line sent by the UART status
// transmitter. Each received byte is checked against the fixed 52-byte
// template
//    "ID:ddd KEY:bbbb_bbbb_bbbb_bbbb R:ddd ddd L:ddd ddd\r\n"
// and the ASCII fields are converted back to binary gamepad values. Decoded
// fields collect in shadow registers and only reach the outputs once the
// whole line has matched, so a partial or corrupt line never disturbs them.
//
// Parameters
//    CLK_FRE      system clock in MHz
//    TIMEOUT_US   max inter-byte gap inside a frame in us
//
// Ports
//    i_sys_clk      in   system clock
//    i_rst_n        in   async active-low reset
//    i_recv_en      in   1-cycle strobe, i_recv_data valid
//    i_recv_data    in   received byte
//    o_PS2_ID       out  decoded ID
//    o_PS2_key      out  decoded key bits, first KEY digit is bit 15
//    o_PS2_RX/RY    out  numbers after "R:"
//    o_PS2_LX/LY    out  numbers after "L:"
//    o_frame_valid  out  1-cycle pulse, new frame committed to outputs
//    o_frame_err    out  1-cycle pulse, frame aborted
//    o_in_frame     out  high while a frame is being received
// ---------------------------------------------------------------------------
module uart_ps2_line_parser #(
   parameter int CLK_FRE    = 50,
   parameter int TIMEOUT_US = 1000
) (
   input  logic        i_sys_clk,
   input  logic        i_rst_n,
   input  logic        i_recv_en,
   input  logic [7:0]  i_recv_data,
   output logic [7:0]  o_PS2_ID,
   output logic [15:0] o_PS2_key,
   output logic [7:0]  o_PS2_RX,
   output logic [7:0]  o_PS2_RY,
   output logic [7:0]  o_PS2_LX,
   output logic [7:0]  o_PS2_LY,
   output logic        o_frame_valid,
   output logic        o_frame_err,
   output logic        o_in_frame
);

   localparam int LIMIT = CLK_FRE * TIMEOUT_US;
   localparam int TW    = $clog2(LIMIT + 1);
   localparam logic [TW-1:0] TIMER_LAST = TW'(LIMIT - 1);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RECV = 2'd1;
   localparam logic [1:0] ST_HUNT = 2'd2;

   localparam logic [7:0] CH_LF = 8'h0A;

   logic [1:0]    state;
   logic [5:0]    pos;
   logic [TW-1:0] timer;
   logic [9:0]    acc;
   logic [7:0]    id_sh, rx_sh, ry_sh, lx_sh, ly_sh;
   logic [15:0]   key_sh;

   logic          is_lit, is_digit, is_bit, grp_start, grp_end;
   logic [7:0]    lit_char;
   logic          byte_ok, overflow, good;
   logic [9:0]    acc_base, acc_calc;
   logic [3:0]    digit_val;

   // Classify the current byte position and give the expected literal.
   always_comb begin
      is_lit    = 1'b0;
      is_digit  = 1'b0;
      is_bit    = 1'b0;
      grp_start = 1'b0;
      grp_end   = 1'b0;
      lit_char  = 8'h00;
      case (pos)
         6'd3, 6'd33, 6'd37, 6'd43, 6'd47: begin
            is_digit  = 1'b1;
            grp_start = 1'b1;
         end
         6'd4, 6'd34, 6'd38, 6'd44, 6'd48: is_digit = 1'b1;
         6'd5, 6'd35, 6'd39, 6'd45, 6'd49: begin
            is_digit = 1'b1;
            grp_end  = 1'b1;
         end
         6'd11, 6'd12, 6'd13, 6'd14, 6'd16, 6'd17, 6'd18, 6'd19,
         6'd21, 6'd22, 6'd23, 6'd24, 6'd26, 6'd27, 6'd28, 6'd29:
            is_bit = 1'b1;
         default: begin
            is_lit = 1'b1;
            case (pos)
               6'd0:                        lit_char = "I";
               6'd1:                        lit_char = "D";
               6'd2, 6'd10, 6'd32, 6'd42:   lit_char = ":";
               6'd6, 6'd30, 6'd36, 6'd40,
               6'd46:                       lit_char = " ";
               6'd7:                        lit_char = "K";
               6'd8:                        lit_char = "E";
               6'd9:                        lit_char = "Y";
               6'd15, 6'd20, 6'd25:         lit_char = "_";
               6'd31:                       lit_char = "R";
               6'd41:                       lit_char = "L";
               6'd50:                       lit_char = 8'h0D;
               6'd51:                       lit_char = CH_LF;
               default:                     lit_char = 8'h00;
            endcase
         end
      endcase
   end

   // The accumulator restarts at every group's first digit, so the running
   // value is computed from zero there instead of from the stale acc.
   always_comb begin
      digit_val = i_recv_data[3:0];
      acc_base  = grp_start ? 10'd0 : acc;
      acc_calc  = (acc_base * 10'd10) + {6'd0, digit_val};
      if (is_lit)
         byte_ok = (i_recv_data == lit_char);
      else if (is_digit)
         byte_ok = (i_recv_data >= "0") && (i_recv_data <= "9");
      else if (is_bit)
         byte_ok = (i_recv_data == "0") || (i_recv_data == "1");
      else
         byte_ok = 1'b0;
      overflow = byte_ok && is_digit && grp_end && (acc_calc > 10'd255);
      good     = byte_ok && !overflow;
   end

   assign o_in_frame = (state == ST_RECV) && (pos != 6'd0);

   // Parser state, shadows and committed outputs. A byte and a timer expiry
   // in the same cycle resolve in favour of the byte because the byte branch
   // is checked first and clears the timer.
   always_ff @(posedge i_sys_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state         <= ST_IDLE;
         pos           <= 6'd0;
         timer         <= '0;
         acc           <= 10'd0;
         id_sh         <= 8'd0;
         rx_sh         <= 8'd0;
         ry_sh         <= 8'd0;
         lx_sh         <= 8'd0;
         ly_sh         <= 8'd0;
         key_sh        <= 16'd0;
         o_PS2_ID      <= 8'd0;
         o_PS2_key     <= 16'd0;
         o_PS2_RX      <= 8'd0;
         o_PS2_RY      <= 8'd0;
         o_PS2_LX      <= 8'd0;
         o_PS2_LY      <= 8'd0;
         o_frame_valid <= 1'b0;
         o_frame_err   <= 1'b0;
      end else begin
         o_frame_valid <= 1'b0;
         o_frame_err   <= 1'b0;
         case (state)
            ST_IDLE: begin
               timer <= '0;
               if (i_recv_en) begin
                  if (good) begin
                     state <= ST_RECV;
                     pos   <= 6'd1;
                  end else begin
                     state <= ST_HUNT;
                  end
               end
            end
            ST_RECV: begin
               if (i_recv_en) begin
                  timer <= '0;
                  if (good) begin
                     if (is_digit) begin
                        acc <= acc_calc;
                        if (grp_end) begin
                           case (pos)
                              6'd5:    id_sh <= acc_calc[7:0];
                              6'd35:   rx_sh <= acc_calc[7:0];
                              6'd39:   ry_sh <= acc_calc[7:0];
                              6'd45:   lx_sh <= acc_calc[7:0];
                              default: ly_sh <= acc_calc[7:0];
                           endcase
                        end
                     end
                     if (is_bit)
                        key_sh <= {key_sh[14:0], i_recv_data[0]};
                     if (pos == 6'd51) begin
                        o_PS2_ID      <= id_sh;
                        o_PS2_key     <= key_sh;
                        o_PS2_RX      <= rx_sh;
                        o_PS2_RY      <= ry_sh;
                        o_PS2_LX      <= lx_sh;
                        o_PS2_LY      <= ly_sh;
                        o_frame_valid <= 1'b1;
                        state         <= ST_IDLE;
                        pos           <= 6'd0;
                     end else begin
                        pos <= pos + 6'd1;
                     end
                  end else begin
                     o_frame_err <= 1'b1;
                     state       <= ST_HUNT;
                     pos         <= 6'd0;
                  end
               end else if (timer == TIMER_LAST) begin
                  o_frame_err <= 1'b1;
                  state       <= ST_IDLE;
                  pos         <= 6'd0;
                  timer       <= '0;
               end else begin
                  timer <= timer + 1'b1;
               end
            end
            ST_HUNT: begin
               pos <= 6'd0;
               if (i_recv_en) begin
                  timer <= '0;
                  if (i_recv_data == CH_LF)
                     state <= ST_IDLE;
               end else if (timer == TIMER_LAST) begin
                  state <= ST_IDLE;
                  timer <= '0;
               end else begin
                  timer <= timer + 1'b1;
               end
            end
            default: begin
               state <= ST_IDLE;
               pos   <= 6'd0;
               timer <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_ps2_line_parser.sv
// ---------------------------------------------------------------------------
// tb_uart_ps2_line_parser
// Directed bench for uart_ps2_line_parser. Lines are built from field values
// with $sformatf, sent byte by byte, and the valid/err pulses are sampled on
// the falling edge after each byte so pulse position inside the line is known.
// A short timeout (100 cycles) keeps the timeout scenario quick.
// ---------------------------------------------------------------------------
module tb_uart_ps2_line_parser;

   localparam int CLK_FRE    = 1;
   localparam int TIMEOUT_US = 100;
   localparam int LIMIT      = CLK_FRE * TIMEOUT_US;

   logic        i_sys_clk = 1'b0;
   logic        i_rst_n;
   logic        i_recv_en;
   logic [7:0]  i_recv_data;
   logic [7:0]  o_PS2_ID, o_PS2_RX, o_PS2_RY, o_PS2_LX, o_PS2_LY;
   logic [15:0] o_PS2_key;
   logic        o_frame_valid, o_frame_err, o_in_frame;

   int checks   = 0;
   int failures = 0;

   uart_ps2_line_parser #(
      .CLK_FRE    (CLK_FRE),
      .TIMEOUT_US (TIMEOUT_US)
   ) dut (
      .i_sys_clk     (i_sys_clk),
      .i_rst_n       (i_rst_n),
      .i_recv_en     (i_recv_en),
      .i_recv_data   (i_recv_data),
      .o_PS2_ID      (o_PS2_ID),
      .o_PS2_key     (o_PS2_key),
      .o_PS2_RX      (o_PS2_RX),
      .o_PS2_RY      (o_PS2_RY),
      .o_PS2_LX      (o_PS2_LX),
      .o_PS2_LY      (o_PS2_LY),
      .o_frame_valid (o_frame_valid),
      .o_frame_err   (o_frame_err),
      .o_in_frame    (o_in_frame)
   );

   always #5 i_sys_clk = ~i_sys_clk;

   initial begin
      #400000;
      $display("[TB] FAIL watchdog: simulation did not finish, got timeout required completion");
      $fatal(1, "[TB] watchdog expired");
   end

   function automatic string make_line(input int id, input logic [15:0] key,
                                       input int rx, input int ry,
                                       input int lx, input int ly);
      return $sformatf("ID:%03d KEY:%04b_%04b_%04b_%04b R:%03d %03d L:%03d %03d\r\n",
                       id, key[15:12], key[11:8], key[7:4], key[3:0],
                       rx, ry, lx, ly);
   endfunction

   // Sends the first nbytes of s; called and returns at a falling edge.
   task automatic send_line(input string s, input int nbytes, input int gap,
                            output int n_err, output int err_pos,
                            output int n_val, output int val_pos);
      n_err = 0; err_pos = -1; n_val = 0; val_pos = -1;
      for (int i = 0; i < nbytes; i++) begin
         i_recv_en   = 1'b1;
         i_recv_data = s[i];
         @(negedge i_sys_clk);
         if (o_frame_err === 1'b1) begin
            n_err++;
            if (err_pos < 0) err_pos = i;
         end
         if (o_frame_valid === 1'b1) begin
            n_val++;
            if (val_pos < 0) val_pos = i;
         end
         if (gap > 0) begin
            i_recv_en = 1'b0;
            repeat (gap) @(negedge i_sys_clk);
         end
      end
      i_recv_en = 1'b0;
   endtask

   task automatic test_reset();
      i_rst_n     = 1'b0;
      i_recv_en   = 1'b0;
      i_recv_data = 8'h00;
      repeat (3) @(negedge i_sys_clk);
      checks++;
      if ({o_PS2_ID, o_PS2_key, o_PS2_RX, o_PS2_RY, o_PS2_LX, o_PS2_LY} !== 56'd0) begin
         failures++;
         $display("[TB] FAIL reset_fields: got %h required 0",
                  {o_PS2_ID, o_PS2_key, o_PS2_RX, o_PS2_RY, o_PS2_LX, o_PS2_LY});
      end
      checks++;
      if ({o_frame_valid, o_frame_err, o_in_frame} !== 3'b000) begin
         failures++;
         $display("[TB] FAIL reset_flags: got %b required 000",
                  {o_frame_valid, o_frame_err, o_in_frame});
      end
      i_rst_n = 1'b1;
      @(negedge i_sys_clk);
   endtask

   task automatic test_basic();
      int ne, ep, nv, vp;
      send_line(make_line(115, 16'hFFFE, 128, 127, 0, 255), 52, 1, ne, ep, nv, vp);
      checks++;
      if (nv !== 1 || vp !== 51 || ne !== 0) begin
         failures++;
         $display("[TB] FAIL basic_pulses: got valid=%0d at %0d err=%0d required valid=1 at 51 err=0",
                  nv, vp, ne);
      end
      checks++;
      if (o_PS2_ID !== 8'h73 || o_PS2_key !== 16'hFFFE) begin
         failures++;
         $display("[TB] FAIL basic_id_key: got %h %h required 73 fffe", o_PS2_ID, o_PS2_key);
      end
      checks++;
      if ({o_PS2_RX, o_PS2_RY, o_PS2_LX, o_PS2_LY} !== {8'd128, 8'd127, 8'd0, 8'd255}) begin
         failures++;
         $display("[TB] FAIL basic_sticks: got %0d %0d %0d %0d required 128 127 0 255",
                  o_PS2_RX, o_PS2_RY, o_PS2_LX, o_PS2_LY);
      end
   endtask

   task automatic test_mismatch();
      int ne, ep, nv, vp;
      string s;
      s = make_line(99, 16'h0001, 1, 1, 1, 1);
      s.putc(4, "X");
      send_line(s, 52, 0, ne, ep, nv, vp);
      checks++;
      if (ne !== 1 || ep !== 4 || nv !== 0) begin
         failures++;
         $display("[TB] FAIL mismatch_pulses: got err=%0d at %0d valid=%0d required err=1 at 4 valid=0",
                  ne, ep, nv);
      end
      checks++;
      if (o_PS2_ID !== 8'd115 || o_PS2_key !== 16'hFFFE) begin
         failures++;
         $display("[TB] FAIL mismatch_hold: got %0d %h required 115 fffe", o_PS2_ID, o_PS2_key);
      end
      // inter-frame noise ending in LF must be dropped silently
      send_line("zz\n", 3, 1, ne, ep, nv, vp);
      checks++;
      if (ne !== 0 || nv !== 0) begin
         failures++;
         $display("[TB] FAIL idle_noise: got err=%0d valid=%0d required 0 0", ne, nv);
      end
      send_line(make_line(2, 16'h1234, 0, 99, 10, 20), 52, 1, ne, ep, nv, vp);
      checks++;
      if (nv !== 1 || ne !== 0 || o_PS2_ID !== 8'd2 || o_PS2_LX !== 8'd10 ||
          o_PS2_LY !== 8'd20 || o_PS2_key !== 16'h1234 || o_PS2_RY !== 8'd99) begin
         failures++;
         $display("[TB] FAIL mismatch_recover: got v=%0d e=%0d id=%0d lx=%0d ly=%0d key=%h ry=%0d required 1 0 2 10 20 1234 99",
                  nv, ne, o_PS2_ID, o_PS2_LX, o_PS2_LY, o_PS2_key, o_PS2_RY);
      end
   endtask

   task automatic test_overflow();
      int ne, ep, nv, vp;
      send_line("ID:256 KEY:0000_0000_0000_0000 R:000 000 L:000 000\r\n", 52, 0, ne, ep, nv, vp);
      checks++;
      if (ne !== 1 || ep !== 5 || nv !== 0) begin
         failures++;
         $display("[TB] FAIL overflow_pulses: got err=%0d at %0d valid=%0d required err=1 at 5 valid=0",
                  ne, ep, nv);
      end
      checks++;
      if (o_PS2_ID !== 8'd2 || o_PS2_key !== 16'h1234) begin
         failures++;
         $display("[TB] FAIL overflow_hold: got %0d %h required 2 1234", o_PS2_ID, o_PS2_key);
      end
      send_line(make_line(200, 16'hA5A5, 1, 2, 3, 250), 52, 2, ne, ep, nv, vp);
      checks++;
      if (nv !== 1 || ne !== 0 || o_PS2_ID !== 8'd200 || o_PS2_key !== 16'hA5A5 ||
          {o_PS2_RX, o_PS2_RY, o_PS2_LX, o_PS2_LY} !== {8'd1, 8'd2, 8'd3, 8'd250}) begin
         failures++;
         $display("[TB] FAIL overflow_recover: got v=%0d e=%0d id=%0d key=%h %0d %0d %0d %0d required 1 0 200 a5a5 1 2 3 250",
                  nv, ne, o_PS2_ID, o_PS2_key, o_PS2_RX, o_PS2_RY, o_PS2_LX, o_PS2_LY);
      end
   endtask

   task automatic test_timeout();
      int ne, ep, nv, vp, terr;
      send_line(make_line(7, 16'h0F0F, 11, 12, 13, 14), 20, 1, ne, ep, nv, vp);
      checks++;
      if (o_in_frame !== 1'b1 || ne !== 0) begin
         failures++;
         $display("[TB] FAIL timeout_inframe: got in_frame=%b err=%0d required 1 0", o_in_frame, ne);
      end
      terr = 0;
      repeat (LIMIT + 5) begin
         @(negedge i_sys_clk);
         if (o_frame_err === 1'b1) terr++;
      end
      checks++;
      if (terr !== 1 || o_in_frame !== 1'b0) begin
         failures++;
         $display("[TB] FAIL timeout_err: got err=%0d in_frame=%b required 1 0", terr, o_in_frame);
      end
      send_line(make_line(9, 16'h8001, 50, 60, 70, 80), 52, 1, ne, ep, nv, vp);
      checks++;
      if (nv !== 1 || ne !== 0 || o_PS2_ID !== 8'd9 || o_PS2_key !== 16'h8001 ||
          {o_PS2_RX, o_PS2_RY, o_PS2_LX, o_PS2_LY} !== {8'd50, 8'd60, 8'd70, 8'd80}) begin
         failures++;
         $display("[TB] FAIL timeout_recover: got v=%0d e=%0d id=%0d key=%h %0d %0d %0d %0d required 1 0 9 8001 50 60 70 80",
                  nv, ne, o_PS2_ID, o_PS2_key, o_PS2_RX, o_PS2_RY, o_PS2_LX, o_PS2_LY);
      end
   endtask

   task automatic test_reset_midframe();
      int ne, ep, nv, vp;
      send_line(make_line(33, 16'h3333, 33, 33, 33, 33), 30, 0, ne, ep, nv, vp);
      #2;
      i_rst_n = 1'b0;
      #1;
      checks++;
      if ({o_PS2_ID, o_PS2_key, o_PS2_RX, o_PS2_RY, o_PS2_LX, o_PS2_LY} !== 56'd0 ||
          o_in_frame !== 1'b0) begin
         failures++;
         $display("[TB] FAIL midreset_zero: got %h in_frame=%b required 0 0",
                  {o_PS2_ID, o_PS2_key, o_PS2_RX, o_PS2_RY, o_PS2_LX, o_PS2_LY}, o_in_frame);
      end
      @(negedge i_sys_clk);
      i_rst_n = 1'b1;
      @(negedge i_sys_clk);
      send_line(make_line(255, 16'h5555, 255, 0, 128, 1), 52, 1, ne, ep, nv, vp);
      checks++;
      if (nv !== 1 || ne !== 0 || o_PS2_ID !== 8'd255 || o_PS2_key !== 16'h5555 ||
          {o_PS2_RX, o_PS2_RY, o_PS2_LX, o_PS2_LY} !== {8'd255, 8'd0, 8'd128, 8'd1}) begin
         failures++;
         $display("[TB] FAIL midreset_recover: got v=%0d e=%0d id=%0d key=%h %0d %0d %0d %0d required 1 0 255 5555 255 0 128 1",
                  nv, ne, o_PS2_ID, o_PS2_key, o_PS2_RX, o_PS2_RY, o_PS2_LX, o_PS2_LY);
      end
   endtask

   task automatic test_back_to_back();
      int ne, ep, nv, vp;
      send_line(make_line(1, 16'hFFFE, 4, 5, 6, 7), 52, 0, ne, ep, nv, vp);
      checks++;
      if (nv !== 1 || vp !== 51 || ne !== 0 || o_PS2_key !== 16'hFFFE || o_PS2_ID !== 8'd1) begin
         failures++;
         $display("[TB] FAIL b2b_first: got v=%0d at %0d e=%0d key=%h id=%0d required 1 51 0 fffe 1",
                  nv, vp, ne, o_PS2_key, o_PS2_ID);
      end
      send_line(make_line(3, 16'h0000, 8, 9, 10, 11), 52, 0, ne, ep, nv, vp);
      checks++;
      if (nv !== 1 || vp !== 51 || ne !== 0 || o_PS2_key !== 16'h0000 || o_PS2_ID !== 8'd3 ||
          {o_PS2_RX, o_PS2_RY, o_PS2_LX, o_PS2_LY} !== {8'd8, 8'd9, 8'd10, 8'd11}) begin
         failures++;
         $display("[TB] FAIL b2b_second: got v=%0d at %0d e=%0d key=%h id=%0d %0d %0d %0d %0d required 1 51 0 0000 3 8 9 10 11",
                  nv, vp, ne, o_PS2_key, o_PS2_ID, o_PS2_RX, o_PS2_RY, o_PS2_LX, o_PS2_LY);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_mismatch();
      test_overflow();
      test_timeout();
      test_reset_midframe();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
